mem_copy_engine: RTL and testbench

- Initiator-side DMA block for the dual-port main memory: accepts a copy command (src, dst, len) and moves len words.
- Reads on memory port a, writes on memory port b, streaming one word per cycle.
- Sits between the processor/control logic and main memory; drives the memory's address/data/wren ports and consumes its read data.

---
 rtl/mem_copy_engine.sv | 113 +++++++++++
 tb/tb_mem_copy_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: streaming word copy between two ports of a dual-port memory.
// Reads on port a, writes on port b, one word per cycle. Port-a read data is
// registered by the memory, so each write trails its read by one cycle.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | cmd_ready high, waiting for a command
//  S_RUN   | issuing one read per cycle; writes start on the 2nd cycle
//  S_DRAIN | last read data returns, final write performed
//  S_DONE  | single-cycle done pulse
module mem_copy_engine #(
   parameter int N  = 24,
   parameter int AW = 20,
   parameter int LW = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_src,
   input  logic [AW-1:0] cmd_dst,
   input  logic [LW-1:0] cmd_len,
   output logic [AW-1:0] mem_address_a,
   output logic [N-1:0]  mem_data_a,
   output logic          mem_wren_a,
   input  logic [N-1:0]  mem_q_a,
   output logic [AW-1:0] mem_address_b,
   output logic [N-1:0]  mem_data_b,
   output logic          mem_wren_b,
   output logic          busy,
   output logic          done,
   output logic [LW-1:0] words_written
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [LW-1:0] remain_q, remain_d;
   logic          rvalid_q, rvalid_d;
   logic [LW-1:0] words_q, words_d;

   // State and datapath registers; async reset kills any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         remain_q  <= '0;
         rvalid_q  <= 1'b0;
         words_q   <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         remain_q  <= remain_d;
         rvalid_q  <= rvalid_d;
         words_q   <= words_d;
      end
   end

   // Next-state logic: remain_q counts reads still to issue down to 1.
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      remain_d  = remain_q;
      rvalid_d  = 1'b0;
      words_d   = words_q;

      if (rvalid_q) begin
         wr_addr_d = wr_addr_q + AW'(1);
         words_d   = words_q + LW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               rd_addr_d = cmd_src;
               wr_addr_d = cmd_dst;
               remain_d  = cmd_len;
               words_d   = '0;
               state_d   = (cmd_len != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            rvalid_d  = 1'b1;
            rd_addr_d = rd_addr_q + AW'(1);
            remain_d  = remain_q - LW'(1);
            if (remain_q == LW'(1)) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Write port follows the read-valid register directly so it drops on reset.
   always_comb begin
      mem_address_a = rd_addr_q;
      mem_data_a    = '0;
      mem_wren_a    = 1'b0;
      mem_address_b = wr_addr_q;
      mem_wren_b    = rvalid_q;
      mem_data_b    = rvalid_q ? mem_q_a : '0;
      cmd_ready     = (state_q == S_IDLE);
      busy          = (state_q != S_IDLE);
      done          = (state_q == S_DONE);
      words_written = words_q;
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural dual-port memory
// (registered port-a read, read-old-data on same-cycle read/write).
module tb_mem_copy_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [19:0] cmd_src = '0;
   logic [19:0] cmd_dst = '0;
   logic [19:0] cmd_len = '0;
   logic [19:0] mem_address_a;
   logic [23:0] mem_data_a;
   logic        mem_wren_a;
   logic [23:0] mem_q_a;
   logic [19:0] mem_address_b;
   logic [23:0] mem_data_b;
   logic        mem_wren_b;
   logic        busy;
   logic        done;
   logic [19:0] words_written;

   logic [23:0] mem [0:1048575];
   logic        pre_we = 1'b0;
   logic [19:0] pre_addr = '0;
   logic [23:0] pre_data = '0;

   int total = 0;
   int bad = 0;

   mem_copy_engine dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .mem_address_a(mem_address_a), .mem_data_a(mem_data_a),
      .mem_wren_a(mem_wren_a), .mem_q_a(mem_q_a),
      .mem_address_b(mem_address_b), .mem_data_b(mem_data_b),
      .mem_wren_b(mem_wren_b),
      .busy(busy), .done(done), .words_written(words_written)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_q_a <= mem[mem_address_a];
      if (mem_wren_b) mem[mem_address_b] <= mem_data_b;
      if (pre_we) mem[pre_addr] <= pre_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [19:0] a, input logic [23:0] d);
      pre_we = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_we = 1'b0;
   endtask

   // Issue one command and check every cycle of the transfer against the
   // expected schedule: reads c1..cL, writes c2..cL+1, done at cL+2.
   task automatic do_copy(input logic [19:0] s, input logic [19:0] d, input int l);
      logic [23:0] exp_d [0:15];
      logic [19:0] a;
      int          nbusy;
      for (int i = 0; i < l; i++) begin
         a = s + 20'(i);
         exp_d[i] = mem[a];
      end
      nbusy = (l == 0) ? 1 : l + 2;
      cmd_src = s;
      cmd_dst = d;
      cmd_len = 20'(l);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int k = 1; k <= nbusy; k++) begin
         chk("busy", 32'(busy), 32'd1);
         chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
         chk("done", 32'(done), 32'(k == nbusy));
         chk("wren_b", 32'(mem_wren_b), 32'(l > 0 && k >= 2 && k <= l + 1));
         if (l > 0 && k >= 2 && k <= l + 1) begin
            a = d + 20'(k - 2);
            chk("addr_b", 32'(mem_address_b), 32'(a));
            chk("data_b", 32'(mem_data_b), 32'(exp_d[k-2]));
         end
         if (k <= l) begin
            a = s + 20'(k - 1);
            chk("addr_a", 32'(mem_address_a), 32'(a));
         end
         tick();
      end
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      chk("idle_wren", 32'(mem_wren_b), 32'd0);
      chk("words_written", 32'(words_written), 32'(l));
   endtask

   initial begin
      // Reset values while rst is held.
      tick();
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wren_b", 32'(mem_wren_b), 32'd0);
      chk("rst_wren_a", 32'(mem_wren_a), 32'd0);
      chk("rst_data_a", 32'(mem_data_a), 32'd0);
      chk("rst_addr_a", 32'(mem_address_a), 32'd0);
      chk("rst_addr_b", 32'(mem_address_b), 32'd0);
      chk("rst_data_b", 32'(mem_data_b), 32'd0);
      chk("rst_words", 32'(words_written), 32'd0);

      preload(20'h100, 24'hA1);
      preload(20'h101, 24'hB2);
      preload(20'h102, 24'hC3);
      preload(20'h103, 24'hD4);
      rst = 1'b0;
      tick();

      // Basic len=4 copy.
      do_copy(20'h100, 20'h200, 4);
      chk("m200", 32'(mem[20'h200]), 32'hA1);
      chk("m201", 32'(mem[20'h201]), 32'hB2);
      chk("m202", 32'(mem[20'h202]), 32'hC3);
      chk("m203", 32'(mem[20'h203]), 32'hD4);

      // len=0: one busy cycle with done, no writes.
      do_copy(20'h100, 20'h250, 0);

      // Source range wraps through 0xFFFFF.
      preload(20'hFFFFE, 24'd1);
      preload(20'hFFFFF, 24'd2);
      preload(20'h00000, 24'd3);
      preload(20'h00001, 24'd4);
      do_copy(20'hFFFFE, 20'h00010, 4);
      chk("wrap10", 32'(mem[20'h10]), 32'd1);
      chk("wrap11", 32'(mem[20'h11]), 32'd2);
      chk("wrap12", 32'(mem[20'h12]), 32'd3);
      chk("wrap13", 32'(mem[20'h13]), 32'd4);

      // dst == src+1 relies on read-old-data.
      preload(20'h10, 24'd5);
      preload(20'h11, 24'd6);
      preload(20'h12, 24'd7);
      preload(20'h13, 24'd8);
      do_copy(20'h10, 20'h11, 4);
      chk("ovl11", 32'(mem[20'h11]), 32'd5);
      chk("ovl12", 32'(mem[20'h12]), 32'd6);
      chk("ovl13", 32'(mem[20'h13]), 32'd7);
      chk("ovl14", 32'(mem[20'h14]), 32'd8);

      // Back-to-back: cmd_valid held, fields changed while busy.
      preload(20'h500, 24'h11);
      preload(20'h501, 24'h22);
      preload(20'h502, 24'h33);
      preload(20'h700, 24'h44);
      preload(20'h701, 24'h55);
      cmd_src = 20'h500;
      cmd_dst = 20'h600;
      cmd_len = 20'd3;
      cmd_valid = 1'b1;
      tick();
      cmd_src = 20'h700;
      cmd_dst = 20'h800;
      cmd_len = 20'd2;
      for (int k = 1; k <= 5; k++) begin
         chk("b2b_busy1", 32'(busy), 32'd1);
         chk("b2b_ready1", 32'(cmd_ready), 32'd0);
         chk("b2b_done1", 32'(done), 32'(k == 5));
         tick();
      end
      chk("b2b_gap_busy", 32'(busy), 32'd0);
      chk("b2b_gap_ready", 32'(cmd_ready), 32'd1);
      chk("b2b_gap_words", 32'(words_written), 32'd3);
      tick();
      cmd_valid = 1'b0;
      chk("b2b_acc_busy", 32'(busy), 32'd1);
      chk("b2b_acc_addr_a", 32'(mem_address_a), 32'h700);
      chk("b2b_acc_words", 32'(words_written), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         chk("b2b_done2", 32'(done), 32'(k == 4));
         tick();
      end
      chk("b2b_end_busy", 32'(busy), 32'd0);
      chk("b2b_words2", 32'(words_written), 32'd2);
      chk("b2b_m600", 32'(mem[20'h600]), 32'h11);
      chk("b2b_m601", 32'(mem[20'h601]), 32'h22);
      chk("b2b_m602", 32'(mem[20'h602]), 32'h33);
      chk("b2b_m800", 32'(mem[20'h800]), 32'h44);
      chk("b2b_m801", 32'(mem[20'h801]), 32'h55);

      // Async reset during the 3rd write of a len=8 copy.
      for (int i = 0; i < 8; i++) begin
         preload(20'h300 + 20'(i), 24'h300 + 24'(i));
         preload(20'h400 + 20'(i), 24'hEEEEEE);
      end
      cmd_src = 20'h300;
      cmd_dst = 20'h400;
      cmd_len = 20'd8;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("ar_wren_before", 32'(mem_wren_b), 32'd1);
      chk("ar_addr_b_before", 32'(mem_address_b), 32'h402);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_wren_async", 32'(mem_wren_b), 32'd0);
      chk("ar_busy_async", 32'(busy), 32'd0);
      chk("ar_ready_async", 32'(cmd_ready), 32'd1);
      tick();
      rst = 1'b0;
      tick();
      chk("ar_idle_busy", 32'(busy), 32'd0);
      chk("ar_idle_wren", 32'(mem_wren_b), 32'd0);
      chk("ar_words", 32'(words_written), 32'd0);
      chk("ar_m400", 32'(mem[20'h400]), 32'h300);
      chk("ar_m401", 32'(mem[20'h401]), 32'h301);
      chk("ar_m402", 32'(mem[20'h402]), 32'hEEEEEE);
      chk("ar_m403", 32'(mem[20'h403]), 32'hEEEEEE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
